// File: rtl/multichannel_moving_average_pkg.sv
// Shared helpers for the multichannel moving-average filter.
//   acc_width()  : accumulator width (sample + window growth + rounding headroom)
//   ch_width()   : channel tag width, never narrower than 1 bit
//   clamp_log2() : limits a requested window exponent to the configured maximum
//   acc_t        : accumulator type for the default configuration
package multichannel_moving_average_pkg;

    localparam int DEF_DATA_WIDTH      = 12;
    localparam int DEF_LOG2_WINDOW_MAX = 4;

    function automatic int acc_width(input int data_w, input int log2_max);
        return data_w + log2_max + 1;
    endfunction

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int clamp_log2(input int req, input int max_log2);
        return (req > max_log2) ? max_log2 : req;
    endfunction

    typedef logic signed [acc_width(DEF_DATA_WIDTH, DEF_LOG2_WINDOW_MAX)-1:0] acc_t;

endpackage

// File: rtl/multichannel_moving_average_if.sv
// Stream/control bundle for multichannel_moving_average.
//   master : sample source (drives window select, flush and the input stream)
//   slave  : the filter (drives the result stream)
interface multichannel_moving_average_if #(
    parameter int DATA_WIDTH = 12,
    parameter int CH_W       = 1,
    parameter int KW         = 3
);
    logic [KW-1:0]                win_log2;
    logic                         flush;
    logic                         in_valid;
    logic [CH_W-1:0]              in_channel;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         out_valid;
    logic [CH_W-1:0]              out_channel;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_primed;

    modport master (
        output win_log2, flush, in_valid, in_channel, in_data,
        input  out_valid, out_channel, out_data, out_primed
    );

    modport slave (
        input  win_log2, flush, in_valid, in_channel, in_data,
        output out_valid, out_channel, out_data, out_primed
    );
endinterface

// File: rtl/multichannel_moving_average_sample_delay_ram.sv
// Simple dual-port synchronous sample store, one region of 2**LOG2_WINDOW_MAX
// entries per channel. No reset: stale contents are masked by the fill counters.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address {channel, pointer}
//   i_wdata : sample to store
//   i_raddr : read address {channel, pointer}
//   o_rdata : registered read data, valid the cycle after the address
module multichannel_moving_average_sample_delay_ram #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 32,
    parameter int AW         = 5
) (
    input  logic                         clk,
    input  logic                         i_we,
    input  logic [AW-1:0]                i_waddr,
    input  logic signed [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]                i_raddr,
    output logic signed [DATA_WIDTH-1:0] o_rdata
);
    logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic signed [DATA_WIDTH-1:0] r_rdata;

    // A same-edge read of the slot being written returns the previous contents:
    // at the largest window the slot being overwritten holds exactly the sample
    // that is leaving the window. A write on an earlier edge is always visible.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/multichannel_moving_average.sv
// Time-multiplexed boxcar filter for NUM_CHANNELS interleaved channels with a
// runtime power-of-two window and a rounded mean output, 2-cycle latency.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : slave side of multichannel_moving_average_if
//          win_log2/flush/in_* in, out_valid/out_channel/out_data/out_primed out
module multichannel_moving_average
    import multichannel_moving_average_pkg::*;
#(
    parameter int DATA_WIDTH      = 12,
    parameter int NUM_CHANNELS    = 2,
    parameter int LOG2_WINDOW_MAX = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    multichannel_moving_average_if.slave  bus
);
    localparam int L     = LOG2_WINDOW_MAX;
    localparam int CH_W  = ch_width(NUM_CHANNELS);
    localparam int KW    = $clog2(L + 1);
    localparam int FW    = L + 1;
    localparam int ACC_W = acc_width(DATA_WIDTH, L);
    localparam int AW    = CH_W + L;
    localparam int DEPTH = NUM_CHANNELS * (2 ** L);

    // Mean with round-half-toward-+inf; the result always fits DATA_WIDTH.
    function automatic logic signed [DATA_WIDTH-1:0] round_mean(
        input logic signed [ACC_W-1:0] sum,
        input logic [KW-1:0]           k
    );
        logic signed [ACC_W-1:0] bias;
        logic signed [ACC_W-1:0] t;
        bias = (k == '0) ? '0 : (ACC_W'(1) << (k - KW'(1)));
        t    = sum + bias;
        t    = t >>> k;
        return DATA_WIDTH'(t);
    endfunction

    logic [KW-1:0]                r_win;
    logic [KW-1:0]                r_k;
    logic [L-1:0]                 r_wptr [NUM_CHANNELS];
    logic [FW-1:0]                r_fill [NUM_CHANNELS];
    logic signed [ACC_W-1:0]      r_acc  [NUM_CHANNELS];

    logic                         r_vld_p1;
    logic [CH_W-1:0]              r_ch_p1;
    logic signed [DATA_WIDTH-1:0] r_data_p1;
    logic [KW-1:0]                r_k_p1;

    logic                         r_vld_p2;
    logic [CH_W-1:0]              r_ch_p2;
    logic signed [ACC_W-1:0]      r_sum_p2;
    logic [KW-1:0]                r_k_p2;
    logic                         r_primed_p2;

    logic                         w_flush;
    logic                         w_ch_ok;
    logic                         w_accept;
    logic [KW-1:0]                w_win_clamped;
    logic [L-1:0]                 w_wptr;
    logic [L-1:0]                 w_back;
    logic [L-1:0]                 w_rptr;
    logic signed [DATA_WIDTH-1:0] w_ram_rdata;
    logic [FW-1:0]                w_fill_p1;
    logic [FW-1:0]                w_span_p1;
    logic                         w_full_p1;
    logic signed [DATA_WIDTH-1:0] w_old_p1;
    logic signed [ACC_W-1:0]      w_acc_new_p1;
    logic [FW-1:0]                w_fill_new_p1;

    assign w_win_clamped = KW'(clamp_log2(int'(bus.win_log2), L));

    // A window change behaves exactly like a flush pulse; r_win already holds
    // the new exponent, so the sample accepted on that edge uses it directly.
    assign w_flush = bus.flush | (r_win != r_k);

    if (NUM_CHANNELS == (1 << CH_W)) begin : g_full_tag
        assign w_ch_ok = 1'b1;
    end else begin : g_partial_tag
        assign w_ch_ok = (int'(bus.in_channel) < NUM_CHANNELS);
    end

    // ---- Stage 0: accept, RAM write and read of the sample leaving the window
    assign w_accept = bus.in_valid & w_ch_ok;
    assign w_wptr   = w_flush ? '0 : r_wptr[bus.in_channel];
    assign w_back   = L'(1) << r_win;   // 2**k mod 2**L; 0 at the largest window
    assign w_rptr   = w_wptr - w_back;

    multichannel_moving_average_sample_delay_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr ({bus.in_channel, w_wptr}),
        .i_wdata (bus.in_data),
        .i_raddr ({bus.in_channel, w_rptr}),
        .o_rdata (w_ram_rdata)
    );

    // ---- Stage 1: per-channel accumulate; old sample only subtracted once full
    assign w_fill_p1     = r_fill[r_ch_p1];
    assign w_span_p1     = FW'(1) << r_k_p1;
    assign w_full_p1     = (w_fill_p1 == w_span_p1);
    assign w_old_p1      = w_full_p1 ? w_ram_rdata : '0;
    assign w_acc_new_p1  = r_acc[r_ch_p1] + ACC_W'(r_data_p1) - ACC_W'(w_old_p1);
    assign w_fill_new_p1 = w_full_p1 ? w_fill_p1 : (w_fill_p1 + FW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win    <= w_win_clamped;
            r_k      <= w_win_clamped;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_wptr[i] <= '0;
                r_fill[i] <= '0;
                r_acc[i]  <= '0;
            end
        end else begin
            r_win    <= w_win_clamped;
            r_k      <= r_win;
            r_vld_p1 <= w_accept;
            r_vld_p2 <= r_vld_p1 & ~w_flush;
            if (w_flush) begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    r_wptr[i] <= '0;
                    r_fill[i] <= '0;
                    r_acc[i]  <= '0;
                end
            end else if (r_vld_p1) begin
                r_acc[r_ch_p1]  <= w_acc_new_p1;
                r_fill[r_ch_p1] <= w_fill_new_p1;
            end
            // Overrides the flush clear for the channel accepted on this edge.
            if (w_accept) begin
                r_wptr[bus.in_channel] <= w_wptr + L'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        r_ch_p1     <= bus.in_channel;
        r_data_p1   <= bus.in_data;
        r_k_p1      <= r_win;
        r_ch_p2     <= r_ch_p1;
        r_sum_p2    <= w_acc_new_p1;
        r_k_p2      <= r_k_p1;
        r_primed_p2 <= (w_fill_new_p1 == w_span_p1);
    end

    // ---- Stage 2: rounded mean; outputs held at zero between results
    assign bus.out_valid   = r_vld_p2;
    assign bus.out_channel = r_vld_p2 ? r_ch_p2 : '0;
    assign bus.out_data    = r_vld_p2 ? round_mean(r_sum_p2, r_k_p2) : '0;
    assign bus.out_primed  = r_vld_p2 & r_primed_p2;

endmodule

// File: tb/tb_multichannel_moving_average.sv
module tb_multichannel_moving_average;
    localparam int DW   = 12;
    localparam int NCH  = 3;
    localparam int LMAX = 4;
    localparam int CHW  = 2;
    localparam int KW   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multichannel_moving_average_if #(.DATA_WIDTH(DW), .CH_W(CHW), .KW(KW)) bus ();

    multichannel_moving_average #(
        .DATA_WIDTH      (DW),
        .NUM_CHANNELS    (NCH),
        .LOG2_WINDOW_MAX (LMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int ch;
        int data;
        bit primed;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    bit   pend_v = 1'b0;
    int   hist [NCH][$];
    int   m_k = 0;
    int   m_win = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int clampw(input int w);
        return (w > LMAX) ? LMAX : w;
    endfunction

    function automatic int floor_div(input int a, input int n);
        int q;
        q = a / n;
        if ((a % n != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Reference: each channel's history since the last flush, trimmed to the
    // window; the mean is the rounded sum over the window length.
    task automatic model_edge(input bit v, input int ch, input int d, input int w, input bit fl);
        bit fl_now;
        int n;
        int sum;
        if (rst) begin
            for (int i = 0; i < NCH; i++) hist[i].delete();
            pend_v = 1'b0;
            while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
            m_k   = clampw(w);
            m_win = m_k;
            return;
        end
        fl_now = fl || (m_win != m_k);
        if (pend_v && !fl_now) sb.push_back(pend);
        pend_v = 1'b0;
        if (fl_now) begin
            for (int i = 0; i < NCH; i++) hist[i].delete();
            m_k = m_win;
        end
        m_win = clampw(w);
        if (v && ch < NCH) begin
            n = 1 << m_k;
            hist[ch].push_back(d);
            while (hist[ch].size() > n) void'(hist[ch].pop_front());
            sum = 0;
            foreach (hist[ch][j]) sum += hist[ch][j];
            pend.ch     = ch;
            pend.data   = floor_div(sum + ((m_k > 0) ? n / 2 : 0), n);
            pend.primed = (hist[ch].size() == n);
            pend.due    = cyc + 2;
            pend_v      = 1'b1;
        end
    endtask

    task automatic drive(input bit v, input int ch, input int d, input int w, input bit fl);
        bus.in_valid   = v;
        bus.in_channel = CHW'(ch);
        bus.in_data    = DW'(d);
        bus.win_log2   = KW'(w);
        bus.flush      = fl;
        model_edge(v, ch, d, w, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input int w);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, w, 1'b0);
    endtask

    // Monitor: every output strobe must match the head of the scoreboard, and
    // every expected result must appear exactly in its due cycle.
    initial begin
        exp_t e;
        bit   due_now;
        forever begin
            @(negedge clk);
            due_now = (sb.size() > 0) && (sb[0].due == cyc);
            if (bus.out_valid || due_now) begin
                checks++;
                if (!due_now) begin
                    errors++;
                    $display("FAIL out_unexpected: got valid ch=%0d data=%0d cycle %0d, required no output",
                             bus.out_channel, bus.out_data, cyc);
                end else begin
                    e = sb.pop_front();
                    if (!bus.out_valid) begin
                        errors++;
                        $display("FAIL out_missing: got no output cycle %0d, required ch=%0d data=%0d",
                                 cyc, e.ch, e.data);
                    end else if (int'(bus.out_channel) != e.ch || int'(bus.out_data) != e.data ||
                                 bus.out_primed != e.primed) begin
                        errors++;
                        $display("FAIL out_value: got ch=%0d data=%0d primed=%0d required ch=%0d data=%0d primed=%0d",
                                 bus.out_channel, bus.out_data, bus.out_primed, e.ch, e.data, e.primed);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_channel = '0; bus.in_data = '0;
        bus.win_log2 = KW'(4); bus.flush = 1'b0;
        drive(1'b0, 0, 0, 4, 1'b0);
        drive(1'b0, 0, 0, 4, 1'b0);
        chk("rst_out_valid",   int'(bus.out_valid), 0);
        chk("rst_out_channel", int'(bus.out_channel), 0);
        chk("rst_out_data",    int'(bus.out_data), 0);
        chk("rst_out_primed",  int'(bus.out_primed), 0);
        rst = 1'b0;
        idle(2, 4);

        // window 16, constant input ramp
        for (int i = 0; i < 20; i++) drive(1'b1, 0, 100, 4, 1'b0);
        idle(3, 4);

        // window 4, full-scale steps
        idle(3, 2);
        for (int i = 0; i < 4; i++) drive(1'b1, 0, 0, 2, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 0, 2047, 2, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 0, -2048, 2, 1'b0);
        idle(3, 2);

        // window 8, interleaved opposite-sign channels
        idle(3, 3);
        for (int i = 0; i < 40; i++) drive(1'b1, i % 2, (i % 2) ? -400 : 400, 3, 1'b0);
        idle(3, 3);

        // window 2, rounding of halves; flush together with a sample
        idle(3, 1);
        drive(1'b1, 0, 1, 1, 1'b0);
        drive(1'b1, 0, 2, 1, 1'b0);
        idle(2, 1);
        drive(1'b1, 0, -1, 1, 1'b1);
        drive(1'b1, 0, -2, 1, 1'b0);
        idle(3, 1);

        // window change mid-stream with a sample on the same cycle
        idle(3, 4);
        for (int i = 0; i < 6; i++) drive(1'b1, 0, 300 + 10 * i, 4, 1'b0);
        drive(1'b1, 0, 555, 1, 1'b0);
        drive(1'b1, 0, 777, 1, 1'b0);
        drive(1'b1, 0, -5, 1, 1'b0);
        drive(1'b1, 0, 9, 1, 1'b0);
        idle(3, 1);

        // out-of-range channel tag mixed in, then reset mid-stream
        idle(3, 2);
        for (int i = 0; i < 20; i++) drive(1'b1, i % 4, int'($urandom_range(0, 4095)) - 2048, 2, 1'b0);
        rst = 1'b1;
        drive(1'b1, 0, 123, 2, 1'b0);
        chk("rst_midstream_out_valid", int'(bus.out_valid), 0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) drive(1'b1, i % 3, 50 * i - 200, 2, 1'b0);
        idle(3, 2);

        // randomized traffic: gaps, bad tags, flushes, window changes incl. clamp
        w = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) w = int'($urandom_range(0, 7));
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? 2047 : -2048)
                                              : int'($urandom_range(0, 4095)) - 2048,
                  w, $urandom_range(0, 39) == 0);
        end
        idle(6, w);
        chk("scoreboard_drained", sb.size() + int'(pend_v), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
